// File: rtl/lfsr_random_gen.sv
// lfsr_random_gen: XNOR-feedback LFSR producing one WIDTH-bit random word per
// request. The seed comes from an explicit seed_in (same cycle or preloaded), or
// from a free-running counter. An optional continuous mode re-runs after each word.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   start      - request a new word (IDLE only)
//   seed_load  - capture seed_in as the seed for the next request (IDLE only)
//   seed_in    - explicit seed value
//   mode       - 0 one-shot, 1 continuous (sampled in DONE)
//   busy       - high whenever the FSM is not IDLE
//   done_tick  - one-cycle pulse, random_num holds a fresh word
//   random_num - LFSR register contents
module lfsr_random_gen #(
   parameter int unsigned      WIDTH  = 14,
   parameter logic [WIDTH-1:0] TAPS   = WIDTH'(14'h2015),
   parameter int unsigned      SHIFTS = WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mode,
   output logic             busy,
   output logic             done_tick,
   output logic [WIDTH-1:0] random_num
);

   localparam int unsigned CW       = $clog2(SHIFTS + 1);
   localparam logic [CW-1:0] SHIFTS_C = CW'(SHIFTS);
   localparam logic [CW-1:0] ONE_C    = CW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] lfsr;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] seed_reg;
   logic             seed_valid;
   logic             fb;
   logic [WIDTH-1:0] seed_sel;
   logic [WIDTH-1:0] seed_fix;

   // XNOR feedback over the tapped bits
   assign fb = ~^(lfsr & TAPS);

   // Seed priority: same-cycle load, then preloaded seed, then counter
   always_comb begin
      seed_sel = q;
      if (seed_load)
         seed_sel = seed_in;
      else if (seed_valid)
         seed_sel = seed_reg;
   end

   // All ones is the XNOR lock-up state; nudge it off by clearing bit 0
   assign seed_fix = (seed_sel == {WIDTH{1'b1}}) ? {seed_sel[WIDTH-1:1], 1'b0} : seed_sel;

   assign random_num = lfsr;

   // Free-running seed counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         q <= '0;
      else
         q <= q + WIDTH'(1);
   end

   // Control FSM with registered busy/done_tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         lfsr       <= '0;
         count      <= '0;
         seed_reg   <= '0;
         seed_valid <= 1'b0;
         busy       <= 1'b0;
         done_tick  <= 1'b0;
      end else begin
         done_tick <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr       <= seed_fix;
                  count      <= SHIFTS_C;
                  seed_valid <= 1'b0;
                  busy       <= 1'b1;
                  state      <= SHIFT;
               end else if (seed_load) begin
                  seed_reg   <= seed_in;
                  seed_valid <= 1'b1;
               end
            end
            SHIFT: begin
               lfsr  <= {lfsr[WIDTH-2:0], fb};
               count <= count - ONE_C;
               // done_tick mirrors DONE, so it is raised on the entering edge
               if (count == ONE_C) begin
                  state     <= DONE;
                  done_tick <= 1'b1;
               end
            end
            DONE: begin
               if (mode) begin
                  count <= SHIFTS_C;
                  state <= SHIFT;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lfsr_random_gen.sv
// Self-checking bench for lfsr_random_gen: default build (SHIFTS=14) plus a
// SHIFTS=1 build. Expected words are queued at start and popped on done_tick.
module tb_lfsr_random_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, seed_load, mode;
   logic [13:0] seed_in;
   logic        busy, done_tick;
   logic [13:0] random_num;
   logic        start_b, seed_load_b, mode_b;
   logic [13:0] seed_in_b;
   logic        busy_b, done_b;
   logic [13:0] random_num_b;

   int n_cmp = 0;
   int n_bad = 0;
   logic [13:0] exp_q [$];
   logic [13:0] mq;

   typedef struct {
      logic [13:0] seed;
      logic [13:0] exp;
   } vec_t;
   vec_t tbl [6];

   lfsr_random_gen dut_a (
      .clk(clk), .reset(reset), .start(start), .seed_load(seed_load),
      .seed_in(seed_in), .mode(mode), .busy(busy), .done_tick(done_tick),
      .random_num(random_num)
   );

   lfsr_random_gen #(.SHIFTS(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .seed_load(seed_load_b),
      .seed_in(seed_in_b), .mode(mode_b), .busy(busy_b), .done_tick(done_b),
      .random_num(random_num_b)
   );

   always #5 clk = ~clk;

   // Reference seed counter
   always @(posedge clk or posedge reset) begin
      if (reset) mq <= '0;
      else       mq <= mq + 14'd1;
   end

   function automatic logic [13:0] fix(input logic [13:0] s);
      return (s == 14'h3FFF) ? 14'h3FFE : s;
   endfunction

   function automatic logic [13:0] run(input logic [13:0] s, input int n);
      logic [13:0] r;
      r = s;
      for (int i = 0; i < n; i++) r = {r[12:0], ~^(r & 14'h2015)};
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every done_tick must match the oldest queued word
   always @(negedge clk) begin : mon
      logic [13:0] e;
      if (!reset && done_tick) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL stray_done: got done_tick=1 expected no pending word at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("word", 32'(random_num), 32'(e));
         end
      end
   end

   // Count negedges until done; lat = number of edges after the start edge
   task automatic wait_done(input bit sel_b, input int limit, output int lat);
      lat = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (sel_b ? done_b : done_tick) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic launch(input logic ld, input logic [13:0] sd, input logic [13:0] exp);
      seed_load = ld;
      seed_in   = sd;
      start     = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      start     = 1'b0;
      seed_load = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic finish_one(input string name, input logic [13:0] exp);
      int lat;
      wait_done(1'b0, 40, lat);
      check({name, "_latency"}, 32'(lat), 32'd14);
      @(negedge clk);
      check({name, "_busy_low"}, 32'(busy), 32'd0);
      check({name, "_idle_hold"}, 32'(random_num), 32'(exp));
   endtask

   task automatic wait_mq(input logic [13:0] v);
      for (int i = 0; i < 20000; i++) begin
         if (mq == v) break;
         @(negedge clk);
      end
      check("counter_reach", 32'(mq), 32'(v));
   endtask

   initial begin
      int lat, lat2, ndone;
      logic [13:0] w1, w2, w3, e;
      reset = 1'b1; start = 0; seed_load = 0; seed_in = '0; mode = 0;
      start_b = 0; seed_load_b = 0; seed_in_b = '0; mode_b = 0;

      tbl[0] = '{14'h0000, 14'h2DCF};
      tbl[1] = '{14'h3FFF, run(14'h3FFE, 14)};
      tbl[2] = '{14'h3FFE, run(14'h3FFE, 14)};
      tbl[3] = '{14'h0001, run(14'h0001, 14)};
      tbl[4] = '{14'h1234, run(14'h1234, 14)};
      tbl[5] = '{14'h2AAA, run(14'h2AAA, 14)};

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done_tick), 32'd0);
      check("rst_num", 32'(random_num), 32'd0);
      check("rst_num_b", 32'(random_num_b), 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Explicit seeds loaded together with start
      for (int i = 0; i < 6; i++) begin
         launch(1'b1, tbl[i].seed, tbl[i].exp);
         finish_one("table", tbl[i].exp);
      end

      // SHIFTS=1 build: single shift, lock-up fix
      seed_load_b = 1; seed_in_b = 14'h0000; start_b = 1;
      @(negedge clk); start_b = 0; seed_load_b = 0;
      wait_done(1'b1, 10, lat);
      check("b_latency", 32'(lat), 32'd1);
      check("b_word0", 32'(random_num_b), 32'h0001);
      @(negedge clk);
      seed_load_b = 1; seed_in_b = 14'h3FFF; start_b = 1;
      @(negedge clk); start_b = 0; seed_load_b = 0;
      wait_done(1'b1, 10, lat);
      check("b_lockfix", 32'(random_num_b), 32'h3FFC);
      @(negedge clk);

      // Preloaded seed, overwritten by a second load, then counter fallback
      seed_load = 1; seed_in = 14'h0ABC; @(negedge clk);
      seed_in = 14'h0DEF; @(negedge clk);
      seed_load = 0; repeat (3) @(negedge clk);
      w1 = run(14'h0DEF, 14);
      launch(1'b0, 14'h0000, w1);
      finish_one("preload", w1);
      e = run(fix(mq), 14);
      launch(1'b0, 14'h0000, e);
      finish_one("ctr_after_preload", e);

      // Counter seed at q=5, then at max, then after wrap
      reset = 1'b1; #2; reset = 1'b0;
      @(negedge clk);
      wait_mq(14'd5);
      launch(1'b0, 14'h0000, run(14'd5, 14));
      finish_one("ctr5", run(14'd5, 14));
      wait_mq(14'h3FFF);
      launch(1'b0, 14'h0000, run(14'h3FFE, 14));
      finish_one("ctr_max", run(14'h3FFE, 14));
      wait_mq(14'h0002);
      launch(1'b0, 14'h0000, run(14'h0002, 14));
      finish_one("ctr_wrap", run(14'h0002, 14));

      // Continuous mode
      w1 = 14'h2DCF; w2 = run(w1, 14); w3 = run(w2, 14);
      mode = 1'b1;
      launch(1'b1, 14'h0000, w1);
      exp_q.push_back(w2);
      exp_q.push_back(w3);
      wait_done(1'b0, 40, lat);
      check("cont_first_lat", 32'(lat), 32'd14);
      wait_done(1'b0, 40, lat);
      check("cont_period", 32'(lat), 32'd15);
      @(negedge clk); mode = 1'b0;
      wait_done(1'b0, 40, lat);
      check("cont_last_period", 32'(lat + 1), 32'd15);
      @(negedge clk);
      check("cont_stop_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      check("cont_queue_empty", 32'(exp_q.size()), 32'd0);

      // start/seed_load during SHIFT are ignored
      w1 = run(14'h0111, 14);
      launch(1'b1, 14'h0111, w1);
      repeat (2) @(negedge clk);
      start = 1; seed_load = 1; seed_in = 14'h1234;
      @(negedge clk); start = 0; seed_load = 0;
      wait_done(1'b0, 40, lat2);
      check("ignore_latency", 32'(lat2 + 3), 32'd14);
      @(negedge clk);
      check("ignore_busy_low", 32'(busy), 32'd0);
      e = run(fix(mq), 14);
      launch(1'b0, 14'h0000, e);
      finish_one("ignore_ctr_seed", e);

      // Asynchronous reset mid-run
      launch(1'b1, 14'h0055, run(14'h0055, 14));
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done_tick), 32'd0);
      check("arst_num", 32'(random_num), 32'd0);
      exp_q.delete();
      @(negedge clk); reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done_tick) ndone++;
      end
      check("arst_no_done", 32'(ndone), 32'd0);
      check("arst_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
